// File: rtl/seq_ctr_pkg.sv
// Shared definitions for the sequential-counter primitives: direction and
// end-of-range mode encodings plus the one-step next-count function.
package seq_ctr_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  typedef struct packed {
    logic [31:0] q;
    logic        wrap;
    logic        sat;
  } ctr_next_t;

  // One count step inside 0..modulus-1. At a range end the count either
  // wraps to the opposite end (wrap flag) or holds (sat flag).
  function automatic ctr_next_t ctr_next(input logic [31:0] q,
                                         input logic        up_dn,
                                         input logic [31:0] modulus,
                                         input logic        saturate);
    ctr_next_t r;
    r.q    = q;
    r.wrap = 1'b0;
    r.sat  = 1'b0;
    if (up_dn == DIR_UP) begin
      if (q == modulus - 32'd1) begin
        if (saturate == MODE_SAT) begin
          r.sat = 1'b1;
        end else begin
          r.q    = 32'd0;
          r.wrap = 1'b1;
        end
      end else begin
        r.q = q + 32'd1;
      end
    end else begin
      if (q == 32'd0) begin
        if (saturate == MODE_SAT) begin
          r.sat = 1'b1;
        end else begin
          r.q    = modulus - 32'd1;
          r.wrap = 1'b1;
        end
      end else begin
        r.q = q - 32'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_updown_counter.sv
// Fully synchronous up/down counter with load, programmable modulus,
// wrap/saturate mode, combinational terminal count and registered wrap/sat.
module sync_updown_counter
  import seq_ctr_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  ctr_next_t        nxt;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    sat_d  = sat_q;
    nxt    = ctr_next(32'(q_q), up_dn, 32'(MODULUS), SATURATE);
    if (load) begin
      // Out-of-range load values clamp to the top of the count range.
      q_d   = (load_val > Q_MAX) ? Q_MAX : load_val;
      sat_d = 1'b0;
    end else if (en) begin
      q_d    = WIDTH'(nxt.q);
      wrap_d = nxt.wrap;
      sat_d  = nxt.sat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  // tc deliberately ignores load; it feeds the next stage's en when cascading.
  assign tc   = en & ((up_dn & (q_q == Q_MAX)) | (~up_dn & (q_q == '0)));
  assign Q    = q_q;
  assign wrap = wrap_q;
  assign sat  = sat_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench: mod-10 wrap and saturate counters plus a two-stage cascade.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  int         errors = 0;
  int         checks = 0;

  // mod-10 wrapping counter
  logic       a_en, a_up, a_load;
  logic [3:0] a_lv, a_q;
  logic       a_tc, a_wrap, a_sat;
  // mod-10 saturating counter
  logic       b_en, b_up, b_load;
  logic [3:0] b_lv, b_q;
  logic       b_tc, b_wrap, b_sat;
  // cascade of two mod-16 stages
  logic       c0_en;
  logic [3:0] c0_q, c1_q;
  logic       c0_tc, c0_wrap, c0_sat, c1_tc, c1_wrap, c1_sat;

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_a (
    .clk(clk), .reset_n(rst_n), .en(a_en), .up_dn(a_up), .load(a_load),
    .load_val(a_lv), .Q(a_q), .tc(a_tc), .wrap(a_wrap), .sat(a_sat));

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_b (
    .clk(clk), .reset_n(rst_n), .en(b_en), .up_dn(b_up), .load(b_load),
    .load_val(b_lv), .Q(b_q), .tc(b_tc), .wrap(b_wrap), .sat(b_sat));

  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_c0 (
    .clk(clk), .reset_n(rst_n), .en(c0_en), .up_dn(1'b1), .load(1'b0),
    .load_val(4'd0), .Q(c0_q), .tc(c0_tc), .wrap(c0_wrap), .sat(c0_sat));

  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_c1 (
    .clk(clk), .reset_n(rst_n), .en(c0_tc), .up_dn(1'b1), .load(1'b0),
    .load_val(4'd0), .Q(c1_q), .tc(c1_tc), .wrap(c1_wrap), .sat(c1_sat));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wraps0, wraps1, wrap1_cyc;
    rst_n = 1'b0;
    a_en = 0; a_up = 1; a_load = 0; a_lv = 0;
    b_en = 0; b_up = 1; b_load = 0; b_lv = 0;
    c0_en = 0;

    // reset
    step(); step();
    chk("rst_a_q", a_q, 0);   chk("rst_a_wrap", a_wrap, 0); chk("rst_a_sat", a_sat, 0);
    chk("rst_b_q", b_q, 0);   chk("rst_b_sat", b_sat, 0);
    chk("rst_c_q", {c1_q, c0_q}, 8'h00);

    // 1: count up through the mod-10 wrap
    rst_n = 1'b1; a_en = 1; a_up = 1;
    #1 chk("up_tc_at0", a_tc, 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("up_q_%0d", i), a_q, i % 10);
      chk($sformatf("up_wrap_%0d", i), a_wrap, (i == 10));
      chk($sformatf("up_tc_%0d", i), a_tc, (i == 9));
    end

    // 2: load 3 then count down through 0 -> 9
    a_load = 1; a_lv = 4'd3;
    step(); chk("ld3_q", a_q, 3);
    a_load = 0; a_up = 0;
    #1 chk("dn_tc_at3", a_tc, 0);
    step(); chk("dn_q_2", a_q, 2); chk("dn_wrap_2", a_wrap, 0);
    step(); chk("dn_q_1", a_q, 1); chk("dn_tc_1", a_tc, 0);
    step(); chk("dn_q_0", a_q, 0); chk("dn_tc_0", a_tc, 1); chk("dn_wrap_0", a_wrap, 0);
    step(); chk("dn_q_9", a_q, 9); chk("dn_wrap_9", a_wrap, 1); chk("dn_tc_9", a_tc, 0);
    step(); chk("dn_q_8", a_q, 8); chk("dn_wrap_8", a_wrap, 0);
    a_en = 0;
    step(); chk("hold_q", a_q, 8); chk("hold_wrap", a_wrap, 0); chk("hold_tc", a_tc, 0);

    // 4: out-of-range load clamps and wins over en
    a_load = 1; a_lv = 4'd13; a_en = 1; a_up = 1;
    step(); chk("clamp_q", a_q, 9); chk("clamp_wrap", a_wrap, 0); chk("clamp_sat", a_sat, 0);
    a_load = 0; a_en = 0;

    // 3: saturating counter at both ends
    b_load = 1; b_lv = 4'd8;
    step(); chk("sat_ld8_q", b_q, 8); chk("sat_ld8_sat", b_sat, 0);
    b_load = 0; b_en = 1; b_up = 1;
    step(); chk("sat_up1_q", b_q, 9); chk("sat_up1_sat", b_sat, 0);
    step(); chk("sat_up2_q", b_q, 9); chk("sat_up2_sat", b_sat, 1); chk("sat_up2_wrap", b_wrap, 0);
    step(); chk("sat_up3_q", b_q, 9); chk("sat_up3_sat", b_sat, 1);
    step(); chk("sat_up4_q", b_q, 9); chk("sat_up4_sat", b_sat, 1); chk("sat_up4_wrap", b_wrap, 0);
    b_en = 0;
    step(); chk("sat_hold_q", b_q, 9); chk("sat_hold_sat", b_sat, 1);
    b_en = 1; b_up = 0;
    step(); chk("sat_dn_q", b_q, 8); chk("sat_dn_sat", b_sat, 0);
    b_load = 1; b_lv = 4'd0;
    step(); chk("sat_ld0_q", b_q, 0);
    b_load = 0;
    #1 chk("sat_tc_lo", b_tc, 1);
    step(); chk("sat_lo_q", b_q, 0); chk("sat_lo_sat", b_sat, 1); chk("sat_lo_wrap", b_wrap, 0);
    b_up = 1;
    step(); chk("sat_lo_up_q", b_q, 1); chk("sat_lo_up_sat", b_sat, 0);
    b_up = 0;
    step(); step(); chk("sat_lo2_sat", b_sat, 1);
    b_load = 1; b_lv = 4'd13;
    step(); chk("sat_clamp_q", b_q, 9); chk("sat_clamp_sat", b_sat, 0);
    b_load = 0; b_up = 1;

    // 5: mid-count reset beats load; sat counter held saturated meanwhile
    a_load = 1; a_lv = 4'd5; a_en = 1; a_up = 1;
    step(); chk("mr_ld5", a_q, 5); chk("mr_b_sat_set", b_sat, 1);
    a_load = 0;
    step(); chk("mr_q6", a_q, 6);
    rst_n = 1'b0; a_load = 1; a_lv = 4'd2;
    #1 chk("mr_between_edges", a_q, 6); chk("mr_b_between", b_sat, 1);
    step();
    chk("mr_a_q", a_q, 0); chk("mr_a_wrap", a_wrap, 0); chk("mr_a_sat", a_sat, 0);
    chk("mr_b_q", b_q, 0); chk("mr_b_sat", b_sat, 0);
    rst_n = 1'b1; a_load = 0; a_en = 0; b_en = 0;

    // 6: two-stage cascade, 260 up counts
    wraps0 = 0; wraps1 = 0; wrap1_cyc = -1;
    c0_en = 1;
    for (int i = 1; i <= 260; i++) begin
      step();
      if (c0_wrap) wraps0++;
      if (c1_wrap) begin wraps1++; wrap1_cyc = i; end
      if (i == 100) chk("casc_100", {c1_q, c0_q}, 8'h64);
    end
    chk("casc_final", {c1_q, c0_q}, 8'h04);
    chk("casc_lo_wraps", wraps0, 16);
    chk("casc_hi_wraps", wraps1, 1);
    chk("casc_hi_wrap_cyc", wrap1_cyc, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_updown_counter.md
Name: sync_updown_counter

Overview:
Parametrised, fully synchronous binary up/down counter. All flops are clocked by the single clock `clk`, so there are no ripple clock chains.
Adds enable, direction select, parallel load, programmable modulus, and wrap or saturate mode. It also provides a combinational terminal-count output for cascading and a registered wrap pulse.
It is the standard counter primitive for timers, dividers and address generators in the sequential-circuits library.

Parameters:
WIDTH, 4, counter width in bits (≥1)
MODULUS, 2**WIDTH, count range is 0..MODULUS-1 (2 ≤ MODULUS ≤ 2**WIDTH)
SATURATE, 0, 0 = wrap at the range ends; 1 = hold at the range ends

Ports:
clk  input  1  clock; all state updates on the rising edge
reset_n  input  1  synchronous, active-low reset
en  input  1  count enable
up_dn  input  1  1 = count up, 0 = count down
load  input  1  synchronous parallel load
load_val  input  WIDTH  value to load
Q  output  WIDTH  current count (registered)
tc  output  1  terminal count (combinational): en & ((up_dn & Q==MODULUS-1) | (~up_dn & Q==0))
wrap  output  1  registered one-cycle pulse, high for the cycle after a wrap occurs
sat  output  1  registered level, high while a saturated count is being held

Behaviour:
- Reset is synchronous and active-low. On a rising edge of clk with reset_n=0: Q=0, wrap=0, sat=0. Reset has priority over every other input.
- Priority on each rising edge: reset > load > en > hold.
- Load (load=1):
  - Q <= load_val if load_val < MODULUS; otherwise Q <= MODULUS-1 (clamp).
  - wrap <= 0, sat <= 0.
  - en and up_dn are ignored.
- Count (en=1, load=0):
  - Up, Q < MODULUS-1: Q <= Q+1.
  - Up, Q == MODULUS-1:
    - SATURATE=0: Q <= 0, wrap <= 1.
    - SATURATE=1: Q holds, sat <= 1.
  - Down, Q > 0: Q <= Q-1.
  - Down, Q == 0:
    - SATURATE=0: Q <= MODULUS-1, wrap <= 1.
    - SATURATE=1: Q holds, sat <= 1.
- Arithmetic is WIDTH bits, with compares against the constant MODULUS-1. No intermediate value ever exceeds MODULUS-1, so no carry bit is retained.
- wrap is high for exactly one cycle after each wrap event. Back-to-back wraps (e.g. MODULUS=2) give wrap high on consecutive cycles.
- sat:
  - Set on the first saturating attempt; stays high while repeated saturating attempts continue.
  - Cleared by any edge where Q changes value, by load, or by reset.
  - en=0 holds sat unchanged.
- Hold (en=0, load=0): Q, sat hold; wrap <= 0.
- Direction change: an up_dn change takes effect on the same edge. There is no pipeline and no dead cycle.
- tc is purely combinational from registered Q and the live en/up_dn. It is intended to drive the en input of the next counter stage so stages cascade synchronously.
  - tc is not gated by load; a loading stage must not rely on tc.
- Latency: Q reflects the load/count on the edge where the inputs are sampled, i.e. one clock.
- Mid-operation reset: takes effect on the next edge regardless of load or en. wrap and sat are forced low on that edge.
- MODULUS == 2**WIDTH: the range compare degenerates to all-ones/all-zeros. The natural binary wrap gives the same result as the explicit rule.

Decomposition:
- Shared package seq_ctr_pkg:
  - constants DIR_UP=1'b1, DIR_DOWN=1'b0
  - constants MODE_WRAP=0, MODE_SAT=1
  - function ctr_next(q, up_dn, modulus, saturate), which returns the next value and the wrap/sat flags
- No sub-module is needed. The flop bank, next-state function call and tc decode live in one module.
- Cascaded wide counters are built by instantiating sync_updown_counter in a parent module, not inside this block.

Test Plan:
1. WIDTH=4, MODULUS=10, SATURATE=0: reset, then en=1, up_dn=1 for 12 clocks -> Q runs 0..9 then 0,1; wrap high only on the cycle after 9->0; tc=1 while Q=9.
2. Same config: load load_val=3, then en=1, up_dn=0 for 5 clocks -> Q = 3,2,1,0,9,8; wrap pulses once after 0->9; tc=1 while Q=0.
3. Same config, SATURATE=1: load 8, up for 4 clocks -> Q = 8,9,9,9; sat=1 from the first hold, wrap stays 0; then one down clock -> Q=8, sat=0.
4. load_val=13 (≥ MODULUS) with load=1 and en=1 on the same edge -> Q=9 (clamped, load wins); wrap=0, sat=0.
5. Mid-count reset: counting up at Q=6, assert reset_n=0 together with load=1 and load_val=2 -> Q=0, wrap=0, sat=0 on that edge; Q does not change between edges (reset is synchronous).
6. Cascade: two WIDTH=4, MODULUS=16 instances, with stage-1 en = stage-0 tc, counting up from 0x00 for 260 clocks -> the {hi, lo} pair reads 0x04, with a stage-1 wrap pulse once at 0xFF->0x00.
